// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and counter type,
// reused by the controller and by downstream pixel generators.
package vga_timing_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1 << CNT_W;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF =
        H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF =
        V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_controller.sv
// VGA raster timing generator: horizontal/vertical counters with registered
// sync, blanking and end-of-frame decodes aligned to pixel_x/pixel_y.
module vga_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             pixel_clk,
    input  logic             reset,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_over
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_controller: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    localparam cnt_t        H_LAST       = cnt_t'(H_TOTAL - 1);
    localparam cnt_t        V_LAST       = cnt_t'(V_TOTAL - 1);
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic h_sync_q, h_sync_d;
    logic v_sync_q, v_sync_d;
    logic video_on_q, video_on_d;
    logic frame_over_q, frame_over_d;

    // Decodes look at the next count so each flag lands in the same cycle
    // as the count it describes.
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
        end

        h_sync_d     = !((32'(h_cnt_d) >= H_SYNC_START) && (32'(h_cnt_d) < H_SYNC_END));
        v_sync_d     = !((32'(v_cnt_d) >= V_SYNC_START) && (32'(v_cnt_d) < V_SYNC_END));
        video_on_d   = (32'(h_cnt_d) < H_VISIBLE) && (32'(v_cnt_d) < V_VISIBLE);
        frame_over_d = (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_sync_q     <= 1'b1;
            v_sync_q     <= 1'b1;
            video_on_q   <= 1'b0;
            frame_over_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            video_on_q   <= video_on_d;
            frame_over_q <= frame_over_d;
        end
    end

    assign pixel_x    = h_cnt_q;
    assign pixel_y    = v_cnt_q;
    assign h_sync     = h_sync_q;
    assign v_sync     = v_sync_q;
    assign video_on   = video_on_q;
    assign frame_over = frame_over_q;

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench: default-timing instance for line timing, reduced-timing
// instance (32x19) so whole frames fit in a short run.
module tb_vga_controller;

    localparam int SH_VIS = 16, SH_FP = 4, SH_SW = 6, SH_BP = 6;
    localparam int SV_VIS = 10, SV_FP = 3, SV_SW = 2, SV_BP = 4;
    localparam int SH_TOT = 32, SV_TOT = 19;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       hs_a, vs_a, vo_a, fo_a, hs_b, vs_b, vo_b, fo_b;
    logic [9:0] px_a, py_a, px_b, py_b;

    vec_t qa[$];
    vec_t qb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ax = 0, ay = 0, bx = 0, by = 0;

    always #5 clk = ~clk;

    vga_controller dut_a (
        .pixel_clk(clk), .reset(rst_a), .h_sync(hs_a), .v_sync(vs_a),
        .video_on(vo_a), .pixel_x(px_a), .pixel_y(py_a), .frame_over(fo_a)
    );

    vga_controller #(
        .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SW), .H_BACK(SH_BP),
        .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SW), .V_BACK(SV_BP)
    ) dut_b (
        .pixel_clk(clk), .reset(rst_b), .h_sync(hs_b), .v_sync(vs_b),
        .video_on(vo_b), .pixel_x(px_b), .pixel_y(py_b), .frame_over(fo_b)
    );

    function automatic vec_t model(int x, int y, int hv, int hf, int hsw,
                                   int vv, int vf, int vsw, int ht, int vt);
        vec_t v;
        v.x  = 10'(x);
        v.y  = 10'(y);
        v.hs = !(x >= hv + hf && x < hv + hf + hsw);
        v.vs = !(y >= vv + vf && y < vv + vf + vsw);
        v.vo = (x < hv) && (y < vv);
        v.fo = (x == ht - 1) && (y == vt - 1);
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v.x  = '0;
        v.y  = '0;
        v.hs = 1'b1;
        v.vs = 1'b1;
        v.vo = 1'b0;
        v.fo = 1'b0;
        return v;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(string tag, vec_t obs, vec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b vo=%b fo=%b, want x=%0d y=%0d hs=%b vs=%b vo=%b fo=%b",
                   tag, $time, obs.x, obs.y, obs.hs, obs.vs, obs.vo, obs.fo,
                   exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.fo);
        end
    endtask

    function automatic vec_t obs_a();
        return {px_a, py_a, hs_a, vs_a, vo_a, fo_a};
    endfunction

    function automatic vec_t obs_b();
        return {px_b, py_b, hs_b, vs_b, vo_b, fo_b};
    endfunction

    // One clock: advance both reference models, queue expectations, then
    // compare against the DUT outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_a) begin
            ax = 0; ay = 0;
            qa.push_back(reset_vec());
        end else begin
            ax++;
            if (ax == 800) begin ax = 0; ay = (ay == 524) ? 0 : ay + 1; end
            qa.push_back(model(ax, ay, 640, 16, 96, 480, 10, 2, 800, 525));
        end
        if (rst_b) begin
            bx = 0; by = 0;
            qb.push_back(reset_vec());
        end else begin
            bx++;
            if (bx == SH_TOT) begin bx = 0; by = (by == SV_TOT - 1) ? 0 : by + 1; end
            qb.push_back(model(bx, by, SH_VIS, SH_FP, SH_SW, SV_VIS, SV_FP, SV_SW, SH_TOT, SV_TOT));
        end
        #1;
        chk_vec("dut_a", obs_a(), qa.pop_front());
        chk_vec("dut_b", obs_b(), qb.pop_front());
    endtask

    initial begin
        int hs_low[4];
        int hs_start[4];
        int vo_cnt[4];
        int fo_edges[$];
        int vs_run, vs_max, vo_b_cnt;
        logic prev_hs;

        rst_a = 1'b1;
        rst_b = 1'b1;
        foreach (hs_low[i]) begin hs_low[i] = 0; hs_start[i] = -1; vo_cnt[i] = 0; end
        vs_run = 0; vs_max = 0; vo_b_cnt = 0; prev_hs = 1'b1;

        // Reset values before any clock edge, then across 100 ns of edges.
        #1;
        qa.push_back(reset_vec());
        qb.push_back(reset_vec());
        chk_vec("a_reset_noclk", obs_a(), qa.pop_front());
        chk_vec("b_reset_noclk", obs_b(), qb.pop_front());
        for (int i = 0; i < 10; i++) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int e = 1; e <= 2400; e++) begin
            tick();
            if (e == 1) begin
                chk("a_first_edge_x", int'(px_a), 1);
                chk("a_first_edge_y", int'(py_a), 0);
            end
            if (e == 800) begin
                chk("a_wrap_x", int'(px_a), 0);
                chk("a_wrap_y", int'(py_a), 1);
            end
            if (py_a < 10'd4) begin
                if (!hs_a) begin
                    hs_low[py_a]++;
                    if (prev_hs) hs_start[py_a] = int'(px_a);
                end
                if (vo_a) vo_cnt[py_a]++;
            end
            prev_hs = hs_a;
            if (fo_b) fo_edges.push_back(e);
            if (e >= 608 && e <= 1215) begin
                vs_run = vs_b ? 0 : vs_run + 1;
                if (vs_run > vs_max) vs_max = vs_run;
                if (vo_b) vo_b_cnt++;
            end
        end

        for (int l = 1; l <= 2; l++) begin
            chk($sformatf("a_hs_low_len_line%0d", l), hs_low[l], 96);
            chk($sformatf("a_hs_start_line%0d", l), hs_start[l], 656);
            chk($sformatf("a_vo_len_line%0d", l), vo_cnt[l], 640);
        end
        chk("b_vs_low_run", vs_max, 2 * SH_TOT);
        chk("b_vo_per_frame", vo_b_cnt, SH_VIS * SV_VIS);
        chk("b_fo_pulses", fo_edges.size(), 3);
        if (fo_edges.size() == 3) begin
            chk("b_fo_first_edge", fo_edges[0], SH_TOT * SV_TOT - 1);
            chk("b_fo_period1", fo_edges[1] - fo_edges[0], SH_TOT * SV_TOT);
            chk("b_fo_period2", fo_edges[2] - fo_edges[1], SH_TOT * SV_TOT);
        end

        // Mid-frame asynchronous reset, asserted away from any clock edge.
        for (int k = 0; k < 700 && py_b !== 10'd5; k++) tick();
        chk("b_reach_mid_frame", int'(py_b), 5);
        #3;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        ax = 0; ay = 0; bx = 0; by = 0;
        qa.push_back(reset_vec());
        qb.push_back(reset_vec());
        chk_vec("a_async_reset", obs_a(), qa.pop_front());
        chk_vec("b_async_reset", obs_b(), qb.pop_front());
        for (int i = 0; i < 3; i++) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        chk("b_resume_x", int'(px_b), 1);
        chk("b_resume_y", int'(py_b), 0);
        for (int i = 0; i < 700; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
